// File: rtl/mem_stage.sv
// MEM pipeline stage. It issues one aligned load or store per instruction on a simple
// req/ack bus and stalls upstream until the bus acknowledges or the timeout expires.
// The MEM/WB outputs are registered. Misaligned accesses and bus timeouts
// each produce a one-cycle fault pulse.
module mem_stage #(
   parameter int unsigned TIMEOUT = 15   // 1..255 BUSY cycles before giving up on mem_ack
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] ctrl_in,
   output logic        stall_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] result_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        misalign_out,
   output logic        bus_err_out
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic        mis_q, mis_d;
   logic        err_q, err_d;

   logic        rd_en, wr_en, access, unsigned_ld, misal;
   logic        is_byte, is_half, is_word;
   logic [3:0]  be;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;

   assign rd_en       = ctrl_in[0];
   assign wr_en       = ctrl_in[1];
   assign access      = rd_en | wr_en;
   assign unsigned_ld = ctrl_in[5];
   assign is_byte     = (ctrl_in[4:3] == 2'b00);
   assign is_half     = (ctrl_in[4:3] == 2'b01);
   assign is_word     = ctrl_in[4];
   assign misal       = (is_half & addr_in[0]) | (is_word & (addr_in[1:0] != 2'b00));

   // Byte-lane selection for the bus and lane extraction for load data
   always_comb begin
      be     = 4'b1111;
      lane_b = mem_rdata[7:0];
      lane_h = addr_in[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (is_byte)      be = 4'b0001 << addr_in[1:0];
      else if (is_half) be = addr_in[1] ? 4'b1100 : 4'b0011;
      case (addr_in[1:0])
         2'b00:   lane_b = mem_rdata[7:0];
         2'b01:   lane_b = mem_rdata[15:8];
         2'b10:   lane_b = mem_rdata[23:16];
         default: lane_b = mem_rdata[31:24];
      endcase
      if (is_byte)      load_data = {{24{~unsigned_ld & lane_b[7]}}, lane_b};
      else if (is_half) load_data = {{16{~unsigned_ld & lane_h[15]}}, lane_h};
      else              load_data = mem_rdata;
   end

   // Bus address and data are derived directly from the held EX/MEM inputs
   assign mem_addr  = {addr_in[31:2], 2'b00};
   assign mem_wdata = is_byte ? {4{wdata_in[7:0]}} :
                      is_half ? {2{wdata_in[15:0]}} : wdata_in;
   assign mem_we    = mem_req & wr_en;
   assign mem_be    = mem_req ? be : 4'b0000;

   // Next-state, stall/request and MEM/WB next values; defaults form a bubble
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      result_d  = '0;
      rd_d      = '0;
      rw_d      = 1'b0;
      mis_d     = 1'b0;
      err_d     = 1'b0;
      stall_out = 1'b0;
      mem_req   = 1'b0;
      if (reset) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (access && !misal) begin
                  stall_out = 1'b1;
                  state_d   = BUSY;
                  cnt_d     = 8'(TIMEOUT);
               end else if (access) begin
                  mis_d = 1'b1;
               end else begin
                  result_d = addr_in;
                  rd_d     = rd_in;
                  rw_d     = ctrl_in[2];
               end
            end
            BUSY: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  state_d  = IDLE;
                  cnt_d    = '0;
                  result_d = wr_en ? addr_in : load_data;
                  rd_d     = rd_in;
                  rw_d     = ctrl_in[2];
               end else if (cnt_q <= 8'd1) begin
                  // The last allowed cycle has expired. Stall is released here so that
                  // upstream retires the faulting instruction and does not reissue it.
                  state_d = IDLE;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  stall_out = 1'b1;
                  cnt_d     = cnt_q - 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, timeout counter and registered MEM/WB outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
         rw_q     <= 1'b0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         rw_q     <= rw_d;
         mis_q    <= mis_d;
         err_q    <= err_d;
      end
   end

   assign result_out    = result_q;
   assign rd_out        = rd_q;
   assign reg_write_out = rw_q;
   assign misalign_out  = mis_q;
   assign bus_err_out   = err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 15, max cycles waiting for mem_ack (legal 1..255).
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: addr_in  input  32  ALU result / effective address from EX/MEM.
REQ-006 SHALL have port: wdata_in  input  32  store data from EX/MEM.
REQ-007 SHALL have port: rd_in  input  5  destination register.
REQ-008 SHALL have port: ctrl_in  input  32  control bits: [0] mem_read, [1] mem_write, [2] reg_write, [4:3] size (00 byte, 01 half, 10/11 word), [5] unsigned load; other bits ignored.
REQ-009 SHALL have port: stall_out  output  1  upstream holds all inputs stable while high.
REQ-010 SHALL have ports: mem_req / mem_we  output  1 / 1  bus request / write enable.
REQ-011 SHALL have ports: mem_addr / mem_wdata  output  32 / 32  word-aligned address (addr_in[1:0]=00) / lane-positioned data.
REQ-012 SHALL have port: mem_be  output  4  byte enables.
REQ-013 SHALL have ports: mem_ack / mem_rdata  input  1 / 32  bus completion / read word.
REQ-014 SHALL have ports: result_out / rd_out / reg_write_out  output  32 / 5 / 1  registered MEM/WB data, destination, write enable.
REQ-015 SHALL have ports: misalign_out / bus_err_out  output  1 / 1  registered one-cycle fault pulses.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 Access = mem_read or mem_write; write SHALL take priority if both are set (no load data).
REQ-018 Misaligned access (half with addr_in[0]=1; word with addr_in[1:0]!=0) SHALL issue no request and no stall, and SHALL give misalign_out=1, reg_write_out=0 next cycle.
REQ-019 Non-access instruction in IDLE SHALL give next edge: result_out=addr_in, rd_out=rd_in, reg_write_out=ctrl_in[2]; stall_out=0.
REQ-020 Aligned access in IDLE SHALL drive stall_out=1 combinationally, go to BUSY, and load the timeout counter with TIMEOUT.
REQ-021 In BUSY, mem_req SHALL be 1 with addr/we/be/wdata constant; stall_out SHALL equal !mem_ack.
REQ-022 Byte enables SHALL be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; mem_wdata replicates byte/half across lanes.
REQ-023 Load extraction SHALL select the byte/half lane by addr_in[1:0] and sign-extend unless ctrl_in[5]=1.
REQ-024 mem_ack in BUSY SHALL cause, next edge: IDLE; result_out = extracted load data (store: addr_in); rd_out=rd_in; reg_write_out=ctrl_in[2].
REQ-025 Aligned load minimum latency SHALL be 2 cycles (present -> BUSY, ack in first BUSY cycle -> result registered).
REQ-026 While stalled, the MEM/WB outputs SHALL hold a bubble: rd_out=0, reg_write_out=0, result_out=0.
REQ-027 The counter SHALL decrement each BUSY cycle without ack; at 0 without ack: next edge IDLE, bus_err_out=1, reg_write_out=0, stall released.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 Fault pulses SHALL last exactly one cycle.

Reset
REQ-030 Reset SHALL force, next edge: IDLE, counter=0, and all registered outputs 0; mem_req=0 and stall_out=0 combinationally.
REQ-031 Reset asserted in BUSY SHALL abandon the access; a concurrent ack SHALL be ignored and no result written.
REQ-032 Initial values SHALL equal reset values.

Verification
REQ-033 Bench SHALL cover: ALU op addr_in=0x1234, rd=5, reg_write=1 -> next cycle result_out=0x1234, rd_out=5, no mem_req.
REQ-034 Bench SHALL cover: signed byte load addr 0x103, rdata 0x80FF0011, ack 1st BUSY cycle -> be=1000, mem_addr=0x100, result_out=0xFFFFFF80 two cycles after present.
REQ-035 Bench SHALL cover: half store addr 0x202, wdata 0xABCD, ack after 3 cycles -> be=1100, mem_wdata=0xABCDABCD, stall high exactly 3 cycles.
REQ-036 Bench SHALL cover: word load addr 0x6 -> misalign_out=1 one cycle, mem_req never 1, stall_out 0.
REQ-037 Bench SHALL cover: TIMEOUT=4, no ack -> bus_err_out=1 one cycle after 4 BUSY cycles, back to IDLE.
REQ-038 Bench SHALL cover: reset in 2nd BUSY cycle with ack -> mem_req 0, all outputs 0, reg_write_out never 1.
